// File: rtl/sawtooth_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sawtooth_monitor_pkg
// Description : Shared types and constants for the sawtooth stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package sawtooth_monitor_pkg;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        FIRST   = 3'd1,
        SEEK    = 3'd2,
        MEASURE = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    localparam int c_err_count_width = 16;

endpackage : sawtooth_monitor_pkg
`default_nettype wire

// File: rtl/sawtooth_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sawtooth_monitor
// Description : Learns the step of a PCM sawtooth stream, measures its period
//               between wraps, declares lock and counts step errors.
// Revision    : 1.0 - initial release
// ============================================================================
module sawtooth_monitor
    import sawtooth_monitor_pkg::*;
#(
    parameter int BIT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int LOCK_COUNT   = 4
) (
    input  logic                         clk_audio,
    input  logic                         reset_n,
    input  logic                         sample_valid,
    input  logic signed [BIT_WIDTH-1:0]  level,
    output logic [BIT_WIDTH-1:0]         step,
    output logic [PERIOD_WIDTH-1:0]      period,
    output logic                         period_valid,
    output logic                         locked,
    output logic                         step_error,
    output logic [c_err_count_width-1:0] error_count
);

    localparam int c_good_width = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [c_good_width-1:0] c_lock_target = c_good_width'(LOCK_COUNT);

    state_t                         r_state;
    logic [BIT_WIDTH-1:0]           r_prev;
    logic [BIT_WIDTH-1:0]           r_step;
    logic [PERIOD_WIDTH-1:0]        r_period;
    logic                           r_period_valid;
    logic                           r_locked;
    logic                           r_step_error;
    logic [c_err_count_width-1:0]   r_error_count;
    logic [PERIOD_WIDTH-1:0]        r_counter;
    logic [c_good_width-1:0]        r_good;

    logic [BIT_WIDTH-1:0]           w_level_u;
    logic [BIT_WIDTH-1:0]           w_diff;
    logic                           w_wrap;
    logic                           w_step_match;
    logic                           w_cnt_sat;
    logic [PERIOD_WIDTH-1:0]        w_counter_inc;
    logic [PERIOD_WIDTH-1:0]        w_period_delta;
    logic                           w_period_good;
    logic [c_good_width-1:0]        w_good_next;

    assign w_level_u     = $unsigned(level);
    assign w_diff        = w_level_u - r_prev;
    assign w_wrap        = !r_prev[BIT_WIDTH-1] && w_level_u[BIT_WIDTH-1];
    assign w_step_match  = (w_diff == r_step);
    assign w_cnt_sat     = &r_counter;
    assign w_counter_inc = w_cnt_sat ? r_counter : r_counter + PERIOD_WIDTH'(1);

    // r_counter already holds the samples since the previous wrap; a stuck
    // counter means the true period is unknown, so it can never be good.
    assign w_period_delta = (r_counter >= r_period) ? (r_counter - r_period)
                                                    : (r_period - r_counter);
    assign w_period_good  = !w_cnt_sat &&
                            ((r_good == '0) || (w_period_delta <= PERIOD_WIDTH'(1)));
    assign w_good_next    = !w_period_good ? c_good_width'(1) :
                            (&r_good)      ? r_good : r_good + c_good_width'(1);

    always_ff @(posedge clk_audio) begin
        if (!reset_n) begin
            r_state        <= EMPTY;
            r_prev         <= '0;
            r_step         <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_step_error   <= 1'b0;
            r_error_count  <= '0;
            r_counter      <= '0;
            r_good         <= '0;
        end else begin
            r_period_valid <= 1'b0;
            r_step_error   <= 1'b0;
            if (sample_valid) begin
                r_prev <= w_level_u;
                case (r_state)
                    EMPTY: r_state <= FIRST;
                    FIRST: begin
                        r_step  <= w_diff;
                        r_state <= SEEK;
                    end
                    default: begin
                        if (!w_step_match) begin
                            // A wrap coinciding with a step error is discarded.
                            r_step_error  <= 1'b1;
                            r_error_count <= (&r_error_count) ? r_error_count
                                           : r_error_count + c_err_count_width'(1);
                            r_step        <= w_diff;
                            r_good        <= '0;
                            r_locked      <= 1'b0;
                            r_state       <= SEEK;
                        end else if (r_state == SEEK) begin
                            if (w_wrap) begin
                                r_counter <= PERIOD_WIDTH'(1);
                                r_state   <= MEASURE;
                            end
                        end else if (w_wrap) begin
                            r_period       <= r_counter;
                            r_period_valid <= 1'b1;
                            r_counter      <= PERIOD_WIDTH'(1);
                            r_good         <= w_good_next;
                            if (w_period_good && (w_good_next >= c_lock_target)) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end else if (!w_period_good) begin
                                r_state  <= MEASURE;
                                r_locked <= 1'b0;
                            end
                        end else begin
                            r_counter <= w_counter_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign step         = r_step;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign step_error   = r_step_error;
    assign error_count  = r_error_count;

endmodule : sawtooth_monitor
`default_nettype wire
